// File: rtl/invaders_hiscore_ctrl_if.sv
// invaders_hiscore_ctrl_if: hiscore access port between the hiscore
// controller (master) and invaders_memory (slave). hs_data_out is valid one
// clock after hs_address is presented.
interface invaders_hiscore_ctrl_if;
    logic [15:0] hs_address;
    logic [7:0]  hs_data_in;
    logic [7:0]  hs_data_out;
    logic        hs_write;
    logic        hs_access;

    modport master (
        output hs_address,
        output hs_data_in,
        output hs_write,
        output hs_access,
        input  hs_data_out
    );

    modport slave (
        input  hs_address,
        input  hs_data_in,
        input  hs_write,
        input  hs_access,
        output hs_data_out
    );
endinterface

// File: rtl/invaders_hiscore_ctrl.sv
// invaders_hiscore_ctrl: waits DELAY_FRAMES vblanks after reset, then on each
// vblank either restores the host-downloaded hiscore image into work RAM
// (followed by a snapshot) or just snapshots the RAM hiscore region into a
// shadow buffer that the host reads back through ul_addr/ul_data.
// Optional feature macro: HISCORE_CHANGE_EN adds the hs_changed pulse output.
module invaders_hiscore_ctrl #(
    parameter logic [15:0] HS_BASE      = 16'h00F4,
    parameter int          HS_LEN       = 2,
    parameter int          DELAY_FRAMES = 60
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        vblank,
    input  logic        dl_wr,
    input  logic [3:0]  dl_addr,
    input  logic [7:0]  dl_data,
    input  logic        dl_done,
    input  logic [3:0]  ul_addr,
    output logic [7:0]  ul_data,
    invaders_hiscore_ctrl_if.master mem
`ifdef HISCORE_CHANGE_EN
    ,
    output logic        hs_changed
`endif
);

    typedef enum logic [1:0] {WAIT_INIT, IDLE, WRITE, READ} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        vblank_q;
    logic        vb_rise;
    logic [7:0]  frame_cnt;
    logic [4:0]  idx;
    logic        restore_pending;
    logic        last_write;
    logic        last_read;
    logic [3:0]  cap_slot;
    logic [7:0]  buf_mem [16];
    logic [7:0]  shadow  [16];

    assign vb_rise    = vblank & ~vblank_q;
    assign last_write = (state == WRITE) && (idx == 5'(HS_LEN - 1));
    assign last_read  = (state == READ)  && (idx == 5'(HS_LEN));
    // Read data lags the address by one clock, so cycle idx fills slot idx-1.
    assign cap_slot   = idx[3:0] - 4'd1;

    // State register.
    always_ff @(posedge Clock or negedge Reset_n) begin
        // NOTE: sequential state always uses <= so every flop samples the
        // pre-edge values regardless of block ordering.
        if (!Reset_n) state <= WAIT_INIT;
        else          state <= state_nxt;
    end

    // Next state: power-up frame delay, per-vblank dispatch, fixed-length bursts.
    always_comb begin
        // NOTE: default assignment first, so no path through the case can
        // leave state_nxt unassigned and infer a latch.
        state_nxt = state;
        case (state)
            WAIT_INIT: if (vb_rise && frame_cnt == 8'(DELAY_FRAMES - 1)) state_nxt = IDLE;
            IDLE:      if (vb_rise) state_nxt = restore_pending ? WRITE : READ;
            WRITE:     if (last_write) state_nxt = READ;
            READ:      if (last_read) state_nxt = IDLE;
            default:   state_nxt = WAIT_INIT;
        endcase
    end

    // Outputs decoded from state; they fall with the async reset of state.
    always_comb begin
        mem.hs_access  = 1'b0;
        mem.hs_write   = 1'b0;
        mem.hs_address = 16'h0000;
        mem.hs_data_in = 8'h00;
        case (state)
            WRITE: begin
                mem.hs_access  = 1'b1;
                mem.hs_write   = 1'b1;
                mem.hs_address = HS_BASE + {11'd0, idx};
                mem.hs_data_in = buf_mem[idx[3:0]];
            end
            READ: begin
                mem.hs_access  = 1'b1;
                mem.hs_address = HS_BASE + {11'd0, idx};
            end
            default: ;
        endcase
    end

    // Edge detect, frame counter, burst index and restore request.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            vblank_q        <= 1'b0;
            frame_cnt       <= 8'd0;
            idx             <= 5'd0;
            restore_pending <= 1'b0;
        end else begin
            vblank_q <= vblank;
            if (state == WAIT_INIT && vb_rise) frame_cnt <= frame_cnt + 8'd1;
            if (state != state_nxt)                  idx <= 5'd0;
            else if (state == WRITE || state == READ) idx <= idx + 5'd1;
            // A new download on the final restore byte wins over the clear.
            if (dl_done)         restore_pending <= 1'b1;
            else if (last_write) restore_pending <= 1'b0;
        end
    end

    // Restore buffer: host writes land in any state.
    always_ff @(posedge Clock) begin
        // NOTE: the restore buffer has no reset; it only ever holds host data
        // and is written before any restore can be requested.
        if (dl_wr && ({1'b0, dl_addr} < 5'(HS_LEN))) buf_mem[dl_addr] <= dl_data;
    end

    // Shadow capture during READ and the registered upload port.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < 16; i++) shadow[i] <= 8'h00;
            ul_data <= 8'h00;
        end else begin
            if (state == READ && idx != 5'd0) shadow[cap_slot] <= mem.hs_data_out;
            ul_data <= ({1'b0, ul_addr} < 5'(HS_LEN)) ? shadow[ul_addr] : 8'h00;
        end
    end

`ifdef HISCORE_CHANGE_EN
    logic after_write;
    logic diff_acc;
    logic cap_diff;

    assign cap_diff = (state == READ) && (idx != 5'd0) && (mem.hs_data_out != shadow[cap_slot]);

    // Change detect: one pulse after a snapshot that differs from the last one.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            after_write <= 1'b0;
            diff_acc    <= 1'b0;
            hs_changed  <= 1'b0;
        end else begin
            if (state == WRITE)     after_write <= 1'b1;
            else if (state == IDLE) after_write <= 1'b0;
            if (state != READ) diff_acc <= 1'b0;
            else if (cap_diff) diff_acc <= 1'b1;
            hs_changed <= last_read && !after_write && (diff_acc || cap_diff);
        end
    end
`endif

endmodule

// File: tb/tb_invaders_hiscore_ctrl.sv
// tb_invaders_hiscore_ctrl: randomized frame-level bench. A reference model
// tracks the expected RAM region, restore buffer, shadow and pending request,
// and predicts the hs_* transaction list of every frame.
module tb_invaders_hiscore_ctrl;
    localparam logic [15:0] HS_BASE      = 16'h00F4;
    localparam int          HS_LEN       = 2;
    localparam int          DELAY_FRAMES = 60;
    localparam int          FRAME_LEN    = 2 * HS_LEN + 8;

    typedef struct {
        logic        w;
        logic [15:0] a;
        logic [7:0]  d;
        int          c;
    } bus_t;

    logic       Clock   = 1'b0;
    logic       Reset_n = 1'b0;
    logic       vblank  = 1'b0;
    logic       dl_wr   = 1'b0;
    logic [3:0] dl_addr = 4'd0;
    logic [7:0] dl_data = 8'd0;
    logic       dl_done = 1'b0;
    logic [3:0] ul_addr = 4'd0;
    logic [7:0] ul_data;
`ifdef HISCORE_CHANGE_EN
    logic       hs_changed;
    int         chg_cnt = 0;
    int         chg_cyc = 0;
`endif

    invaders_hiscore_ctrl_if hs_bus ();

    invaders_hiscore_ctrl #(
        .HS_BASE(HS_BASE), .HS_LEN(HS_LEN), .DELAY_FRAMES(DELAY_FRAMES)
    ) dut (
        .Clock(Clock), .Reset_n(Reset_n), .vblank(vblank),
        .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data), .dl_done(dl_done),
        .ul_addr(ul_addr), .ul_data(ul_data), .mem(hs_bus)
`ifdef HISCORE_CHANGE_EN
        , .hs_changed(hs_changed)
`endif
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    // Memory model: request sampled mid-cycle, acted on at the next edge.
    logic [7:0]  ram [65536];
    logic        req_acc = 1'b0, req_wr = 1'b0;
    logic [15:0] req_addr = 16'h0;
    logic [7:0]  req_data = 8'h0;
    logic        poke_en = 1'b0;
    logic [15:0] poke_addr = 16'h0;
    logic [7:0]  poke_val = 8'h0;

    always @(negedge Clock) begin
        req_acc  = hs_bus.hs_access;
        req_wr   = hs_bus.hs_write;
        req_addr = hs_bus.hs_address;
        req_data = hs_bus.hs_data_in;
    end

    always @(posedge Clock) begin
        if (req_acc) begin
            hs_bus.hs_data_out <= ram[req_addr];
            if (req_wr) ram[req_addr] <= req_data;
        end
        if (poke_en) ram[poke_addr] <= poke_val;
    end

    // Bus monitor.
    bus_t bus_log [$];
    int   bad_wr = 0;
    always @(negedge Clock) begin
        if (Reset_n) begin
            if (hs_bus.hs_access) begin
                bus_t e;
                e.w = hs_bus.hs_write;
                e.a = hs_bus.hs_address;
                e.d = hs_bus.hs_data_in;
                e.c = cyc;
                bus_log.push_back(e);
            end
            if (hs_bus.hs_write && !hs_bus.hs_access) bad_wr++;
`ifdef HISCORE_CHANGE_EN
            if (hs_changed) begin
                chg_cnt++;
                chg_cyc = cyc;
            end
`endif
        end
    end

    // Reference model state.
    logic [7:0] m_buf    [16];
    logic [7:0] m_shadow [16];
    logic [7:0] exp_ram  [16];
    int         m_frames  = 0;
    bit         m_ready   = 0;
    bit         m_pending = 0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic dl_write(input logic [3:0] a, input logic [7:0] d);
        dl_wr = 1'b1; dl_addr = a; dl_data = d;
        tick();
        dl_wr = 1'b0;
        if (a < HS_LEN) m_buf[a] = d;
    endtask

    task automatic pulse_done();
        dl_done = 1'b1;
        tick();
        dl_done = 1'b0;
        m_pending = 1;
    endtask

    task automatic set_ram(input int k, input logic [7:0] v);
        poke_en = 1'b1; poke_addr = HS_BASE + 16'(k); poke_val = v;
        tick();
        poke_en = 1'b0;
        exp_ram[k] = v;
    endtask

    task automatic check_ul(input logic [3:0] a);
        ul_addr = a;
        tick();
        check("ul_data", {24'd0, ul_data}, (a < HS_LEN) ? {24'd0, m_shadow[a]} : 32'd0);
    endtask

    task automatic check_all_ul();
        for (int a = 0; a <= HS_LEN; a++) check_ul(4'(a));
        check_ul(4'hF);
    endtask

    // One vblank frame; done_off schedules a dl_done pulse at that cycle
    // offset (-1 none), inject adds a second vblank edge two cycles in.
    task automatic run_frame(input int done_off, input bit inject);
        int          start, base_idx, n_exp, k;
        bit          do_write;
        logic [31:0] got, exp;
`ifdef HISCORE_CHANGE_EN
        int          chg0;
        bit          any_diff;
        chg0     = chg_cnt;
        any_diff = 0;
`endif
        base_idx = bus_log.size();
        start    = cyc;
        do_write = m_ready && m_pending;
        vblank   = 1'b1;
        for (int t = 1; t <= FRAME_LEN; t++) begin
            tick();
            vblank  = inject ? (t == 2) : (t < 2);
            dl_done = (t == done_off);
        end
        vblank  = 1'b0;
        dl_done = 1'b0;

        n_exp = 0;
        if (!m_ready) begin
            m_frames++;
            if (m_frames == DELAY_FRAMES) m_ready = 1;
            if (done_off > 0) m_pending = 1;
        end else begin
            n_exp = (do_write ? HS_LEN : 0) + HS_LEN + 1;
            if (do_write) for (int i = 0; i < HS_LEN; i++) exp_ram[i] = m_buf[i];
            for (int i = 0; i < HS_LEN; i++) begin
`ifdef HISCORE_CHANGE_EN
                if (m_shadow[i] != exp_ram[i]) any_diff = 1;
`endif
                m_shadow[i] = exp_ram[i];
            end
            if (do_write)          m_pending = (done_off >= HS_LEN);
            else if (done_off > 0) m_pending = 1;
        end

        check("n_access", bus_log.size() - base_idx, n_exp);
        for (int i = 0; i < n_exp && base_idx + i < bus_log.size(); i++) begin
            bus_t e;
            e = bus_log[base_idx + i];
            if (do_write && i < HS_LEN) begin
                got = {7'd0, e.w, e.a, e.d};
                exp = {7'd0, 1'b1, HS_BASE + 16'(i), m_buf[i]};
            end else begin
                k = i - (do_write ? HS_LEN : 0);
                if (k < HS_LEN) begin
                    got = {7'd0, e.w, e.a, 8'h00};
                    exp = {7'd0, 1'b0, HS_BASE + 16'(k), 8'h00};
                end else begin
                    got = {31'd0, e.w};
                    exp = 32'd0;
                end
            end
            check("bus", got, exp);
            if (i == 0 || i == n_exp - 1) check("bus_cycle", e.c, start + 1 + i);
        end
`ifdef HISCORE_CHANGE_EN
        check("chg_count", chg_cnt - chg0, (!do_write && any_diff) ? 1 : 0);
        if (chg_cnt != chg0) check("chg_cycle", chg_cyc, start + n_exp + 1);
`endif
    endtask

    task automatic run_init();
        for (int f = 0; f < DELAY_FRAMES; f++) run_frame(-1, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            m_buf[i] = 8'h00; m_shadow[i] = 8'h00; exp_ram[i] = 8'h00;
        end
        tick();
        tick();
        check("rst_access", hs_bus.hs_access, 0);
        check("rst_write", hs_bus.hs_write, 0);
        check("rst_address", hs_bus.hs_address, 0);
        check("rst_data_in", hs_bus.hs_data_in, 0);
        check("rst_ul_data", ul_data, 0);
        for (int k = 0; k <= HS_LEN; k++) set_ram(k, 8'($urandom));
        set_ram(0, 8'h12);
        set_ram(1, 8'h34);
        Reset_n = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) dl_write(4'(i), 8'($urandom));
        check_ul(4'd0);

        // Power-up delay, then first snapshot.
        run_init();
        run_frame(-1, 0);
        check_all_ul();

        // Host restore of AB/CD.
        dl_write(4'd0, 8'hAB);
        dl_write(4'd1, 8'hCD);
        pulse_done();
        run_frame(-1, 0);
        check_all_ul();
        run_frame(-1, 0);

        // Restore requested again on the final restore byte, then a vblank
        // edge in the middle of a snapshot.
        pulse_done();
        run_frame(HS_LEN, 0);
        run_frame(-1, 0);
        run_frame(-1, 1);
        check_all_ul();

        // RAM change between frames, then an unchanged frame.
        set_ram(1, exp_ram[1] + 8'd1);
        run_frame(-1, 0);
        run_frame(-1, 0);
        check_all_ul();

        // Randomized frames.
        for (int f = 0; f < 25; f++) begin
            int r;
            if ($urandom_range(0, 2) == 0)
                repeat ($urandom_range(1, 3)) dl_write(4'($urandom_range(0, 15)), 8'($urandom));
            if ($urandom_range(0, 3) == 0) pulse_done();
            if ($urandom_range(0, 2) == 0) set_ram(int'($urandom_range(0, HS_LEN - 1)), 8'($urandom));
            r = int'($urandom_range(0, 5));
            run_frame((r == 0) ? HS_LEN : ((r == 1) ? int'($urandom_range(1, FRAME_LEN - 1)) : -1),
                      $urandom_range(0, 4) == 0);
            check_all_ul();
        end

        // Reset in the middle of a restore.
        pulse_done();
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        check("mid_write_access", hs_bus.hs_access, 1);
        check("mid_write_write", hs_bus.hs_write, 1);
        #1 Reset_n = 1'b0;
        #1;
        check("async_rst_access", hs_bus.hs_access, 0);
        check("async_rst_write", hs_bus.hs_write, 0);
        tick();
        tick();
        Reset_n = 1'b1;
        tick();
        m_frames  = 0;
        m_ready   = 0;
        m_pending = 0;
        for (int i = 0; i < 16; i++) m_shadow[i] = 8'h00;
        check_all_ul();

        // A restore requested during the delay is carried out after it.
        pulse_done();
        run_init();
        run_frame(-1, 0);
        check_all_ul();
        run_frame(-1, 0);

        check("write_without_access", bad_wr, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
